// File: rtl/counter_sched_311_pkg.sv
// Shared state and mode definitions for the counter_sched_311 sequencing controller.
package counter_sched_pkg_311;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_sched_311_prescaler.sv
// Prescale divider: emits a tick every div+1 enabled clocks; clear restarts the phase.
module prescaler_311 #(
  parameter int PW = 8
) (
  input  logic          clk_311,
  input  logic          reset_311,
  input  logic          clear,
  input  logic          enable,
  input  logic [PW-1:0] div,
  output logic          tick
);

  logic [PW-1:0] cnt;

  assign tick = enable && !clear && (cnt == div);

  always_ff @(posedge clk_311 or negedge reset_311) begin
    if (!reset_311) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (cnt == div) ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/counter_sched_311.sv
// Start/stop/pause sequencer for the 8-bit up counter with prescaled ticks and done pulse.
// Optional capture register enabled by defining SNAPSHOT_EN.
module counter_sched_311
  import counter_sched_pkg_311::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = 8
) (
  input  logic             clk_311,
  input  logic             reset_311,
  input  logic             start_311,
  input  logic             stop_311,
  input  logic             pause_311,
  input  logic             mode_311,
  input  logic [WIDTH-1:0] term_311,
  input  logic [PW-1:0]    presc_311,
  output logic [WIDTH-1:0] count_311,
  output logic             busy_311,
  output logic             done_311,
`ifdef SNAPSHOT_EN
  input  logic             capture_311,
  output logic [WIDTH-1:0] snap_311,
`endif
  output logic [1:0]       state_311
);

  state_t           state;
  logic [WIDTH-1:0] term_sh;
  logic [PW-1:0]    presc_sh;
  logic             mode_sh;
  logic             start_ok;
  logic             presc_clear;
  logic             presc_enable;
  logic             tick;

  assign start_ok     = start_311 && ((state == S_IDLE) || (state == S_DONE));
  assign presc_clear  = stop_311 || start_ok;
  // Gating with pause freezes the prescale phase on the same edge the count freezes.
  assign presc_enable = (state == S_RUN) && !pause_311;
  assign state_311    = state;

  prescaler_311 #(.PW(PW)) u_prescaler (
    .clk_311   (clk_311),
    .reset_311 (reset_311),
    .clear     (presc_clear),
    .enable    (presc_enable),
    .div       (presc_sh),
    .tick      (tick)
  );

  always_ff @(posedge clk_311 or negedge reset_311) begin
    if (!reset_311) begin
      state     <= S_IDLE;
      count_311 <= '0;
      busy_311  <= 1'b0;
      done_311  <= 1'b0;
      term_sh   <= '0;
      presc_sh  <= '0;
      mode_sh   <= MODE_ONESHOT;
    end else begin
      done_311 <= 1'b0;
      if (stop_311) begin
        state     <= S_IDLE;
        count_311 <= '0;
        busy_311  <= 1'b0;
      end else if (start_ok) begin
        term_sh   <= term_311;
        presc_sh  <= presc_311;
        mode_sh   <= mode_311;
        count_311 <= '0;
        state     <= S_RUN;
        busy_311  <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (pause_311) begin
              state <= S_PAUSE;
            end else if (tick) begin
              if (count_311 == term_sh) begin
                done_311 <= 1'b1;
                if (mode_sh == MODE_RELOAD) begin
                  count_311 <= '0;
                end else begin
                  state    <= S_DONE;
                  busy_311 <= 1'b0;
                end
              end else begin
                count_311 <= count_311 + WIDTH'(1);
              end
            end
          end
          S_PAUSE: begin
            if (!pause_311) state <= S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SNAPSHOT_EN
  always_ff @(posedge clk_311 or negedge reset_311) begin
    if (!reset_311) begin
      snap_311 <= '0;
    end else if (capture_311) begin
      snap_311 <= count_311;
    end
  end
`endif

endmodule

// File: tb/tb_counter_sched_311.sv
// Scoreboard bench for counter_sched_311: driver pushes model results, monitor compares on negedge.
module tb_counter_sched_311;

  logic       clk_311 = 1'b0;
  logic       reset_311, start_311, stop_311, pause_311, mode_311;
  logic [7:0] term_311, presc_311;
  logic [7:0] count_311;
  logic       busy_311, done_311;
  logic [1:0] state_311;
`ifdef SNAPSHOT_EN
  logic       capture_311;
  logic [7:0] snap_311;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_311 = ~clk_311;

  counter_sched_311 #(.WIDTH(8), .PW(8)) dut (
    .clk_311     (clk_311),
    .reset_311   (reset_311),
    .start_311   (start_311),
    .stop_311    (stop_311),
    .pause_311   (pause_311),
    .mode_311    (mode_311),
    .term_311    (term_311),
    .presc_311   (presc_311),
    .count_311   (count_311),
    .busy_311    (busy_311),
    .done_311    (done_311),
`ifdef SNAPSHOT_EN
    .capture_311 (capture_311),
    .snap_311    (snap_311),
`endif
    .state_311   (state_311)
  );

  typedef struct {
    int count;
    int busy;
    int done;
    int state;
    int snap;
  } exp_t;

  exp_t q[$];

  // Reference model: state numbers 0..3, phase = clocks elapsed in the current tick period.
  int m_st, m_cnt, m_phase, m_term, m_presc, m_mode, m_done, m_snap;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_st = 0; m_cnt = 0; m_phase = 0; m_term = 0; m_presc = 0;
    m_mode = 0; m_done = 0; m_snap = 0;
  endfunction

  function automatic void model_step(input bit st, input bit sp, input bit pz, input bit cap,
                                     input int md, input int tm, input int pr);
    m_done = 0;
    if (cap) m_snap = m_cnt;
    if (sp) begin
      m_st = 0; m_cnt = 0; m_phase = 0;
    end else if (st && (m_st == 0 || m_st == 3)) begin
      m_term = tm; m_presc = pr; m_mode = md;
      m_cnt = 0; m_phase = 0; m_st = 1;
    end else if (m_st == 1) begin
      if (pz) m_st = 2;
      else begin
        m_phase++;
        if (m_phase == m_presc + 1) begin
          m_phase = 0;
          if (m_cnt == m_term) begin
            m_done = 1;
            if (m_mode == 1) m_cnt = 0;
            else m_st = 3;
          end else begin
            m_cnt++;
          end
        end
      end
    end else if (m_st == 2 && !pz) begin
      m_st = 1;
    end
  endfunction

  task automatic cycle(input bit st, input bit sp, input bit pz, input int md,
                       input int tm, input int pr, input bit cap);
    exp_t e;
    @(negedge clk_311);
    start_311 = st; stop_311 = sp; pause_311 = pz;
    mode_311 = md[0]; term_311 = 8'(tm); presc_311 = 8'(pr);
`ifdef SNAPSHOT_EN
    capture_311 = cap;
`endif
    @(posedge clk_311);
    model_step(st, sp, pz, cap, md, tm, pr);
    e.count = m_cnt;
    e.busy  = (m_st == 1 || m_st == 2) ? 1 : 0;
    e.done  = m_done;
    e.state = m_st;
    e.snap  = m_snap;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic start_cmd(input int md, input int tm, input int pr);
    cycle(1'b1, 1'b0, 1'b0, md, tm, pr, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, int'(count_311), 0);
    check({tag, "_busy"},  int'(busy_311),  0);
    check({tag, "_done"},  int'(done_311),  0);
    check({tag, "_state"}, int'(state_311), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_311);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("count", int'(count_311), e.count);
        check("busy",  int'(busy_311),  e.busy);
        check("done",  int'(done_311),  e.done);
        check("state", int'(state_311), e.state);
`ifdef SNAPSHOT_EN
        check("snap",  int'(snap_311),  e.snap);
`endif
      end
    end
  end

  initial begin : driver
    reset_311 = 1'b0; start_311 = 1'b0; stop_311 = 1'b0; pause_311 = 1'b0;
    mode_311 = 1'b0; term_311 = '0; presc_311 = '0;
`ifdef SNAPSHOT_EN
    capture_311 = 1'b0;
`endif
    model_reset();
    #7;
    check_zero("reset");
    #1 reset_311 = 1'b1;

    // One-shot, term 3, presc 0
    start_cmd(0, 3, 0);
    idle(6);
    // Auto-reload, term 2, presc 1, from DONE
    start_cmd(1, 2, 1);
    idle(30);
    // Pause at count 5 for 4 clocks
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
    start_cmd(0, 20, 0);
    idle(5);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);
    idle(5);
    // start+stop together in RUN, then ignored restart without re-latch
    cycle(1'b1, 1'b1, 1'b0, 1, 1, 0, 1'b0);
    start_cmd(0, 20, 0);
    idle(3);
    start_cmd(1, 1, 3);
    idle(25);
    // term 0 auto-reload: done every clock
    start_cmd(1, 0, 0);
    idle(5);
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
`ifdef SNAPSHOT_EN
    start_cmd(0, 20, 0);
    idle(7);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
    idle(5);
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
`endif
    // Full-width terminal, then asynchronous reset mid-count
    start_cmd(1, 255, 0);
    idle(600);
    @(negedge clk_311);
    #2 reset_311 = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge clk_311);
    #1 check_zero("reset_hold");
    reset_311 = 1'b1;
    idle(3);
    start_cmd(0, 5, 2);
    idle(25);

    // Randomized command mix
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 6) == 0), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 9) == 0));
    end

    @(negedge clk_311);
    #1;
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
